// File: rtl/mem_rr_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state type and default sizing for the memory round-robin arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 8;
endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first requester at or above rr_ptr wins with wrap
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [PW-1:0]      grant,
  output logic               any_req
);
  logic [PW-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
      grant = req[idx] ? idx : grant;
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin sharing of one single-port memory among NUM_REQ requesters
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          req_err,
  output logic [WIDTH-1:0]              req_rdata,
  output logic                          mem_valid,
  output logic                          mem_wr_rd,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic [WIDTH-1:0]              mem_rdata,
  input  logic                          mem_ready,
  output logic                          busy
);
  localparam int PW = $clog2(NUM_REQ);
  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("DEPTH exceeds the address space");
  end
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, rr_ptr_n, grant, grant_n, pick;
  logic any_req;
  logic [7:0] cnt, cnt_n;
  logic mem_valid_n, mem_wr_rd_n, req_err_n, busy_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [WIDTH-1:0] mem_wdata_n, req_rdata_n;
  logic [NUM_REQ-1:0] req_ready_n, gnt_hot;
  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req(req_valid),
    .rr_ptr(rr_ptr),
    .grant(pick),
    .any_req(any_req)
  );
  assign gnt_hot = NUM_REQ'(1) << grant;
  always_comb begin
    state_n = state;
    rr_ptr_n = rr_ptr;
    grant_n = grant;
    cnt_n = cnt;
    mem_valid_n = 1'b0;
    mem_wr_rd_n = mem_wr_rd;
    mem_addr_n = mem_addr;
    mem_wdata_n = mem_wdata;
    req_ready_n = '0;
    req_err_n = 1'b0;
    req_rdata_n = req_rdata;
    unique case (state)
      IDLE: if (any_req) begin
        state_n = ISSUE;
        grant_n = pick;
        mem_valid_n = 1'b1;
        mem_wr_rd_n = req_wr_rd[pick];
        mem_addr_n = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_n = req_wr_rd[pick] ? req_wdata[int'(pick)*WIDTH +: WIDTH] : mem_wdata;
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n = '0;
      end
      WAIT: begin
        cnt_n = cnt + 8'd1;
        if (mem_ready || cnt == 8'(TIMEOUT - 1)) begin
          state_n = DONE;
          req_ready_n = gnt_hot;
          req_err_n = !mem_ready;
          req_rdata_n = (mem_ready && !mem_wr_rd) ? mem_rdata : req_rdata;
        end
      end
      DONE: begin
        state_n = IDLE;
        rr_ptr_n = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      cnt <= '0;
      mem_valid <= 1'b0;
      mem_wr_rd <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      req_ready <= '0;
      req_err <= 1'b0;
      req_rdata <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      grant <= grant_n;
      cnt <= cnt_n;
      mem_valid <= mem_valid_n;
      mem_wr_rd <= mem_wr_rd_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      req_ready <= req_ready_n;
      req_err <= req_err_n;
      req_rdata <= req_rdata_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: scoreboard bench with a one-cycle memory model and per-requester agents
module tb_mem_rr_arbiter;
  typedef struct packed {logic wr; logic [4:0] addr; logic [15:0] data; logic mut;} rq_t;
  typedef struct packed {logic wr; logic [4:0] addr; logic [15:0] data;} mexp_t;
  typedef struct packed {logic [1:0] idx; logic err; logic rd; logic [15:0] rdata; logic [7:0] pgap; logic [7:0] vgap;} cexp_t;
  logic clk = 1'b0, rst = 1'b1, hang = 1'b0;
  logic [3:0] req_valid = '0, req_wr_rd = '0, req_ready;
  logic [19:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic req_err, mem_valid, mem_wr_rd, busy;
  logic [15:0] req_rdata, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic mem_ready = 1'b0;
  logic [4:0] mem_addr;
  logic [15:0] mem [32];
  int cyc = 0, compared = 0, mismatched = 0;
  mexp_t exp_m [$];
  cexp_t exp_c [$];
  mem_rr_arbiter #(.WIDTH(16), .DEPTH(32), .ADDR_WIDTH(5), .NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr_rd(req_wr_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_err(req_err), .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (mem_valid && !hang) begin
      mem_ready <= 1'b1;
      if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction
  function automatic logic [63:0] outs();
    return {19'b0, busy, mem_valid, mem_wr_rd, mem_addr, mem_wdata, req_ready, req_err, req_rdata};
  endfunction
  rq_t rq [4][16];
  logic [3:0] n_rq [4] = '{default: '0};
  logic [3:0] hd [4] = '{default: '0};
  logic [3:0] mutd = '0;
  rq_t e;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        hd[i] = hd[i] + 4'd1;
        mutd[i] = 1'b0;
      end
      e = rq[i][hd[i]];
      if (mem_valid && req_valid[i] && e.mut) mutd[i] = 1'b1;
      req_valid[i] = hd[i] < n_rq[i];
      req_wr_rd[i] = e.wr;
      req_addr[i*5 +: 5] = mutd[i] ? ~e.addr : e.addr;
      req_wdata[i*16 +: 16] = mutd[i] ? ~e.data : e.data;
    end
  end
  mexp_t m;
  cexp_t c;
  logic prev_mv = 1'b0;
  int last_mv = 0, last_done = 0;
  always @(negedge clk) begin
    if (mem_valid) begin
      chk("mem_valid_one_cycle", 64'(prev_mv), 64'(0));
      last_mv = cyc;
      if (exp_m.size() == 0) chk("mem_unexpected", 64'(mem_addr), 64'hFFFF);
      else begin
        m = exp_m.pop_front();
        chk("mem_wr_rd", 64'(mem_wr_rd), 64'(m.wr));
        chk("mem_addr", 64'(mem_addr), 64'(m.addr));
        if (m.wr) chk("mem_wdata", 64'(mem_wdata), 64'(m.data));
      end
    end
    prev_mv = mem_valid;
    if (req_ready != 4'b0) begin
      if (exp_c.size() == 0) chk("req_ready_unexpected", 64'(req_ready), 64'(0));
      else begin
        c = exp_c.pop_front();
        chk("req_ready", 64'(req_ready), 64'(4'b1 << c.idx));
        chk("req_err", 64'(req_err), 64'(c.err));
        if (c.rd) chk("req_rdata", 64'(req_rdata), 64'(c.rdata));
        chk("valid_to_ready", 64'(cyc - last_mv), 64'(c.vgap));
        if (c.pgap != 8'd0) chk("ready_spacing", 64'(cyc - last_done), 64'(c.pgap));
      end
      last_done = cyc;
    end
  end
  task automatic push(input int i, input logic wr, input logic [4:0] a, input logic [15:0] d, input logic mut);
    rq[i][n_rq[i]] = {wr, a, d, mut};
    n_rq[i] = n_rq[i] + 4'd1;
  endtask
  task automatic em(input logic wr, input logic [4:0] a, input logic [15:0] d);
    exp_m.push_back({wr, a, d});
  endtask
  task automatic ec(input logic [1:0] idx, input logic err, input logic rd, input logic [15:0] rdata, input logic [7:0] pgap, input logic [7:0] vgap);
    exp_c.push_back({idx, err, rd, rdata, pgap, vgap});
  endtask
  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while ((exp_c.size() != 0 || exp_m.size() != 0 || busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_drain"}, 64'(k < 300), 64'(1));
    if (k >= 300) begin
      exp_c.delete();
      exp_m.delete();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish before 100000");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int k;
    int t0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 64'(0));
    rst = 1'b0;
    em(1'b1, 5'd5, 16'hA5A5);
    ec(2'd0, 1'b0, 1'b0, 16'h0, 8'd0, 8'd2);
    @(posedge clk); #1;
    t0 = cyc;
    push(0, 1'b1, 5'd5, 16'hA5A5, 1'b0);
    wait_done("t1_write");
    chk("t1_latency", 64'(last_done - t0), 64'(3));
    em(1'b0, 5'd5, 16'h0);
    ec(2'd0, 1'b0, 1'b1, 16'hA5A5, 8'd0, 8'd2);
    @(posedge clk); #1;
    push(0, 1'b0, 5'd5, 16'h0, 1'b0);
    wait_done("t1_read");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) em(1'b1, 5'(8 + i), 16'(16'h1000 + i));
    for (int i = 0; i < 4; i++) em(1'b0, 5'(8 + i), 16'h0);
    for (int i = 0; i < 4; i++) ec(2'(i), 1'b0, 1'b0, 16'h0, (i == 0) ? 8'd0 : 8'd4, 8'd2);
    for (int i = 0; i < 4; i++) ec(2'(i), 1'b0, 1'b1, 16'(16'h1000 + i), 8'd4, 8'd2);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      push(i, 1'b1, 5'(8 + i), 16'(16'h1000 + i), 1'b0);
      push(i, 1'b0, 5'(8 + i), 16'h0, 1'b0);
    end
    wait_done("t2");
    em(1'b1, 5'd20, 16'h2000);
    ec(2'd1, 1'b0, 1'b0, 16'h0, 8'd0, 8'd2);
    @(posedge clk); #1;
    push(1, 1'b1, 5'd20, 16'h2000, 1'b0);
    wait_done("t3_setup");
    em(1'b1, 5'd21, 16'h3001);
    em(1'b1, 5'd23, 16'h1101);
    em(1'b1, 5'd22, 16'h3002);
    em(1'b1, 5'd24, 16'h1102);
    ec(2'd3, 1'b0, 1'b0, 16'h0, 8'd0, 8'd2);
    ec(2'd1, 1'b0, 1'b0, 16'h0, 8'd4, 8'd2);
    ec(2'd3, 1'b0, 1'b0, 16'h0, 8'd4, 8'd2);
    ec(2'd1, 1'b0, 1'b0, 16'h0, 8'd4, 8'd2);
    @(posedge clk); #1;
    push(1, 1'b1, 5'd23, 16'h1101, 1'b0);
    push(1, 1'b1, 5'd24, 16'h1102, 1'b0);
    push(3, 1'b1, 5'd21, 16'h3001, 1'b0);
    push(3, 1'b1, 5'd22, 16'h3002, 1'b0);
    wait_done("t3");
    hang = 1'b1;
    em(1'b1, 5'd2, 16'hBEEF);
    ec(2'd0, 1'b1, 1'b0, 16'h0, 8'd0, 8'd9);
    @(posedge clk); #1;
    push(0, 1'b1, 5'd2, 16'hBEEF, 1'b0);
    wait_done("t4_timeout");
    hang = 1'b0;
    em(1'b0, 5'd10, 16'h0);
    ec(2'd2, 1'b0, 1'b1, 16'h1002, 8'd0, 8'd2);
    @(posedge clk); #1;
    push(2, 1'b0, 5'd10, 16'h0, 1'b0);
    wait_done("t4_recover");
    hang = 1'b1;
    em(1'b0, 5'd9, 16'h0);
    em(1'b0, 5'd9, 16'h0);
    em(1'b1, 5'd25, 16'h5555);
    ec(2'd2, 1'b0, 1'b1, 16'h1001, 8'd0, 8'd2);
    ec(2'd3, 1'b0, 1'b0, 16'h0, 8'd4, 8'd2);
    @(posedge clk); #1;
    push(2, 1'b0, 5'd9, 16'h0, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_valid && k < 20);
    chk("t5_issue_seen", 64'(mem_valid), 64'(1));
    @(negedge clk);
    push(3, 1'b1, 5'd25, 16'h5555, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_reset_outputs", outs(), 64'(0));
    rst = 1'b0;
    hang = 1'b0;
    wait_done("t5");
    em(1'b1, 5'd12, 16'h6666);
    em(1'b0, 5'd12, 16'h0);
    ec(2'd0, 1'b0, 1'b0, 16'h0, 8'd0, 8'd2);
    ec(2'd0, 1'b0, 1'b1, 16'h6666, 8'd4, 8'd2);
    @(posedge clk); #1;
    push(0, 1'b1, 5'd12, 16'h6666, 1'b1);
    push(0, 1'b0, 5'd12, 16'h0, 1'b0);
    wait_done("t6");
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
